// File: rtl/recover_pkg.sv
// Shared constants, FSM state type and index helper for the recover_2n_FFT feed path.
package recover_pkg;

  localparam int unsigned N_POINTS = 8192;
  localparam int unsigned ADDR_W   = 13;
  localparam int unsigned IDX_W    = 11;
  localparam int unsigned BEATS    = N_POINTS / 8 + 1;
  localparam int unsigned LANE_W   = 27;

  typedef logic [3:0][LANE_W-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } fsm_state_e;

  function automatic logic [IDX_W-1:0] bitrev11(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] r;
    for (int unsigned i = 0; i < IDX_W; i++) begin
      r[i] = v[IDX_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/feed_bank_ram.sv
// One spectrum bank: simple dual-port RAM, one write port, registered 1-cycle read.
module feed_bank_ram
  import recover_pkg::*;
#(
  parameter int unsigned DEPTH = N_POINTS / 8,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/recover_feed_sequencer.sv
// Buffers X1/X2 spectra in 8 banks each and replays them as the 1025-beat
// bit-reversed column stream consumed by recover_2n_FFT.
module recover_feed_sequencer #(
  parameter int unsigned DATA_WIDTH = recover_pkg::LANE_W,
  parameter int unsigned N_POINTS   = recover_pkg::N_POINTS,
  parameter int unsigned ADDR_W     = recover_pkg::ADDR_W,
  parameter int unsigned IDX_W      = recover_pkg::IDX_W,
  parameter int unsigned BEATS      = recover_pkg::BEATS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [63:0]                wr_x1,
  input  logic [63:0]                wr_x2,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       valid,
  output logic [3:0][DATA_WIDTH-1:0] x1_col1_r,
  output logic [3:0][DATA_WIDTH-1:0] x1_col1_i,
  output logic [3:0][DATA_WIDTH-1:0] x2_col1_r,
  output logic [3:0][DATA_WIDTH-1:0] x2_col1_i,
  output logic [3:0][DATA_WIDTH-1:0] x1_col2_r,
  output logic [3:0][DATA_WIDTH-1:0] x1_col2_i,
  output logic [3:0][DATA_WIDTH-1:0] x2_col2_r,
  output logic [3:0][DATA_WIDTH-1:0] x2_col2_i,
  output logic [IDX_W-1:0]           index_col_1,
  output logic [IDX_W-1:0]           index_col_2
);
  import recover_pkg::*;

  localparam int unsigned ROWS  = N_POINTS / 8;
  localparam int unsigned ROW_W = ADDR_W - 3;

  fsm_state_e       state_q, state_d;
  logic [IDX_W-1:0] beat_q, beat_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic             hi_q, hi_d;
  logic             pair_q, pair_d;
  logic [IDX_W-1:0] idx1_q, idx1_d;
  logic [IDX_W-1:0] idx2_q, idx2_d;

  logic             wr_ok;
  logic [7:0]       bank_we;
  logic [ROW_W-1:0] rd_row;
  logic [63:0]      x1_rd [8];
  logic [63:0]      x2_rd [8];
  logic [2:0]       c1_bank;
  logic             unused_bits;

  assign wr_ok = wr_en && (state_q == IDLE || state_q == DONE);

  // Beats 0 and 1 both read row 0 (low/high half); beat b>=2 reads row b-1.
  assign rd_row = (beat_q < IDX_W'(2)) ? '0 : ROW_W'(beat_q - IDX_W'(1));

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      bank_we[i] = wr_ok && (wr_addr[2:0] == 3'(i));
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_bank
    feed_bank_ram #(.DEPTH(ROWS), .WIDTH(64), .AW(ROW_W)) u_x1 (
      .clk   (clk),
      .we    (bank_we[g]),
      .waddr (wr_addr[ADDR_W-1:3]),
      .wdata (wr_x1),
      .raddr (rd_row),
      .rdata (x1_rd[g])
    );
    feed_bank_ram #(.DEPTH(ROWS), .WIDTH(64), .AW(ROW_W)) u_x2 (
      .clk   (clk),
      .we    (bank_we[g]),
      .waddr (wr_addr[ADDR_W-1:3]),
      .wdata (wr_x2),
      .raddr (rd_row),
      .rdata (x2_rd[g])
    );
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = 1'b0;
    hi_d    = 1'b0;
    pair_d  = 1'b0;
    idx1_d  = '0;
    idx2_d  = '0;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        valid_d = 1'b1;
        hi_d    = (beat_q == IDX_W'(1));
        pair_d  = (beat_q >= IDX_W'(2));
        idx1_d  = bitrev11(beat_q);
        idx2_d  = (beat_q >= IDX_W'(2)) ? bitrev11(beat_q) : '0;
        beat_d  = beat_q + IDX_W'(1);
        if (beat_q == IDX_W'(BEATS - 1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      hi_q    <= 1'b0;
      pair_q  <= 1'b0;
      idx1_q  <= '0;
      idx2_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      hi_q    <= hi_d;
      pair_q  <= pair_d;
      idx1_q  <= idx1_d;
      idx2_q  <= idx2_d;
    end
  end

  // RAM read data is already registered; the lane flags qualify and zero it.
  always_comb begin
    c1_bank = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      c1_bank      = {hi_q, 2'(j)};
      x1_col1_r[j] = '0;
      x1_col1_i[j] = '0;
      x2_col1_r[j] = '0;
      x2_col1_i[j] = '0;
      x1_col2_r[j] = '0;
      x1_col2_i[j] = '0;
      x2_col2_r[j] = '0;
      x2_col2_i[j] = '0;
      if (valid_q) begin
        x1_col1_r[j] = x1_rd[c1_bank][32 +: DATA_WIDTH];
        x1_col1_i[j] = x1_rd[c1_bank][0 +: DATA_WIDTH];
        x2_col1_r[j] = x2_rd[c1_bank][32 +: DATA_WIDTH];
        x2_col1_i[j] = x2_rd[c1_bank][0 +: DATA_WIDTH];
      end
      if (pair_q) begin
        x1_col2_r[j] = x1_rd[j+4][32 +: DATA_WIDTH];
        x1_col2_i[j] = x1_rd[j+4][0 +: DATA_WIDTH];
        x2_col2_r[j] = x2_rd[j+4][32 +: DATA_WIDTH];
        x2_col2_i[j] = x2_rd[j+4][0 +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    unused_bits = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      unused_bits = unused_bits ^ (^{x1_rd[k][63:32+DATA_WIDTH], x1_rd[k][31:DATA_WIDTH],
                                     x2_rd[k][63:32+DATA_WIDTH], x2_rd[k][31:DATA_WIDTH]});
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign valid       = valid_q;
  assign index_col_1 = idx1_q;
  assign index_col_2 = idx2_q;

endmodule

// File: tb/tb_recover_feed_sequencer.sv
// Self-checking bench for recover_feed_sequencer: array model of X1/X2 plus beat-mapping rules.
module tb_recover_feed_sequencer;

  typedef logic [3:0][26:0] lane_t;
  typedef struct packed {
    lane_t x1c1r, x1c1i, x2c1r, x2c1i, x1c2r, x1c2i, x2c2r, x2c2i;
    logic [10:0] i1, i2;
  } beat_t;
  typedef struct {
    int beat; int c1; int c2; logic [10:0] i1; logic [10:0] i2;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, wr_en, start, busy, done, valid;
  logic [12:0] wr_addr;
  logic [63:0] wr_x1, wr_x2;
  lane_t x1_col1_r, x1_col1_i, x2_col1_r, x2_col1_i;
  lane_t x1_col2_r, x1_col2_i, x2_col2_r, x2_col2_i;
  logic [10:0] index_col_1, index_col_2;

  recover_feed_sequencer #(.DATA_WIDTH(27), .N_POINTS(8192), .ADDR_W(13), .IDX_W(11), .BEATS(1025)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x1(wr_x1), .wr_x2(wr_x2),
    .start(start), .busy(busy), .done(done), .valid(valid),
    .x1_col1_r(x1_col1_r), .x1_col1_i(x1_col1_i), .x2_col1_r(x2_col1_r), .x2_col1_i(x2_col1_i),
    .x1_col2_r(x1_col2_r), .x1_col2_i(x1_col2_i), .x2_col2_r(x2_col2_r), .x2_col2_i(x2_col2_i),
    .index_col_1(index_col_1), .index_col_2(index_col_2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [63:0] m1 [8192];
  logic [63:0] m2 [8192];
  beat_t cap [1025];
  int r_nvalid, r_first, r_last, r_done_cyc, r_ndone, r_rise, r_fall;
  bit r_gap, r_after_bad;

  task automatic check(input bit ok, input string name, input string got, input string exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %s expected %s", name, got, exp);
    end
  endtask

  function automatic int bitrev_ref(input int b);
    int r = 0;
    for (int k = 0; k < 11; k++) r = r * 2 + ((b >> k) & 1);
    return r;
  endfunction

  function automatic beat_t expect_beat(input int b);
    beat_t e = '0;
    int s;
    for (int j = 0; j < 4; j++) begin
      s = (b < 2) ? b * 4 + j : (b - 1) * 8 + j;
      e.x1c1r[j] = m1[s][58:32]; e.x1c1i[j] = m1[s][26:0];
      e.x2c1r[j] = m2[s][58:32]; e.x2c1i[j] = m2[s][26:0];
      if (b >= 2) begin
        s = (b - 1) * 8 + 4 + j;
        e.x1c2r[j] = m1[s][58:32]; e.x1c2i[j] = m1[s][26:0];
        e.x2c2r[j] = m2[s][58:32]; e.x2c2i[j] = m2[s][26:0];
      end
    end
    e.i1 = 11'(bitrev_ref(b));
    if (b >= 2) e.i2 = e.i1;
    return e;
  endfunction

  function automatic beat_t grab();
    beat_t g;
    g.x1c1r = x1_col1_r; g.x1c1i = x1_col1_i; g.x2c1r = x2_col1_r; g.x2c1i = x2_col1_i;
    g.x1c2r = x1_col2_r; g.x1c2i = x1_col2_i; g.x2c2r = x2_col2_r; g.x2c2i = x2_col2_i;
    g.i1 = index_col_1; g.i2 = index_col_2;
    return g;
  endfunction

  function automatic bit out_zero();
    return !valid && !done && x1_col1_r == '0 && x1_col1_i == '0 && x2_col1_r == '0 &&
           x2_col1_i == '0 && x1_col2_r == '0 && x1_col2_i == '0 && x2_col2_r == '0 &&
           x2_col2_i == '0 && index_col_1 == '0 && index_col_2 == '0;
  endfunction

  task automatic load_dut(input int from);
    for (int k = from; k < 8192; k++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 13'(k); wr_x1 = m1[k]; wr_x2 = m2[k];
    end
  endtask

  // Pulses start, observes up to 1100 cycles; optional mid-run write+start or reset.
  task automatic run_frame(input bit wr_with_start, input int inj_at, input int abort_at);
    int cyc = 0;
    int a;
    bit aborted = 0;
    r_nvalid = 0; r_first = -1; r_last = -1; r_done_cyc = -1; r_ndone = 0;
    r_rise = -1; r_fall = -1; r_gap = 0; r_after_bad = 0;
    @(negedge clk);
    start = 1'b1;
    wr_en = wr_with_start;
    if (wr_with_start) begin
      wr_addr = '0; wr_x1 = m1[0]; wr_x2 = m2[0];
    end
    while (cyc < 1100 && !aborted && !(r_done_cyc >= 0 && cyc >= r_done_cyc + 3)) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; wr_en = 1'b0;
      if (valid) begin
        if (r_nvalid == 0) r_first = cyc;
        else if (cyc != r_last + 1) r_gap = 1;
        if (r_nvalid < 1025) cap[r_nvalid] = grab();
        r_nvalid++;
        r_last = cyc;
      end
      if (done) begin
        r_ndone++;
        if (r_done_cyc < 0) r_done_cyc = cyc;
      end
      if (busy && r_rise < 0) r_rise = cyc;
      if (!busy && r_rise >= 0 && r_fall < 0) r_fall = cyc;
      if (r_done_cyc >= 0 && cyc > r_done_cyc && !out_zero()) r_after_bad = 1;
      if (cyc == inj_at) begin
        a = $urandom_range(0, 8191);
        wr_en = 1'b1; wr_addr = 13'(a); wr_x1 = ~m1[a]; wr_x2 = ~m2[a]; start = 1'b1;
      end
      if (abort_at >= 0 && r_nvalid == abort_at + 1) begin
        rst_n = 1'b0;
        #1;
        check(out_zero() && !busy, "abort_reset_outputs",
              $sformatf("valid=%0b busy=%0b idx1=%h", valid, busy, index_col_1), "all zero");
        aborted = 1;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
  endtask

  task automatic frame_checks(input string tag);
    int mism = 0;
    int first_bad = -1;
    beat_t e;
    check(r_first == 2, {tag, "_latency"}, $sformatf("%0d", r_first), "2");
    check(r_nvalid == 1025 && !r_gap, {tag, "_valid_count"},
          $sformatf("%0d gap=%0b", r_nvalid, r_gap), "1025 gap=0");
    check(r_ndone == 1 && r_done_cyc == r_last + 1, {tag, "_done"},
          $sformatf("n=%0d at=%0d", r_ndone, r_done_cyc), $sformatf("n=1 at=%0d", r_last + 1));
    check(r_rise == 1 && r_fall == r_done_cyc && r_fall > 0, {tag, "_busy"},
          $sformatf("rise=%0d fall=%0d", r_rise, r_fall), $sformatf("rise=1 fall=%0d", r_done_cyc));
    check(!r_after_bad, {tag, "_idle_after"}, $sformatf("bad=%0b", r_after_bad), "bad=0");
    for (int b = 0; b < 1025 && b < r_nvalid; b++) begin
      e = expect_beat(b);
      if (cap[b] !== e) begin
        mism++;
        if (first_bad < 0) first_bad = b;
      end
    end
    check(mism == 0 && r_nvalid >= 1025, {tag, "_frame_data"},
          $sformatf("%0d bad beats (first %0d) of %0d", mism, first_bad, r_nvalid), "0 bad of 1025");
  endtask

  vec_t tbl [6];
  lane_t e1r, e2i, e1c2, e2c2;
  beat_t cb;

  initial begin
    tbl[0] = '{0,    0,    -1,   11'h000, 11'h000};
    tbl[1] = '{1,    4,    -1,   11'h400, 11'h000};
    tbl[2] = '{2,    8,    12,   11'h200, 11'h200};
    tbl[3] = '{3,    16,   20,   11'h600, 11'h600};
    tbl[4] = '{513,  4096, 4100, 11'h402, 11'h402};
    tbl[5] = '{1024, 8184, 8188, 11'h001, 11'h001};

    rst_n = 1'b0; wr_en = 1'b0; start = 1'b0; wr_addr = '0; wr_x1 = '0; wr_x2 = '0;
    repeat (3) @(negedge clk);
    check(out_zero() && !busy, "reset_state", $sformatf("valid=%0b busy=%0b", valid, busy), "all zero");
    rst_n = 1'b1;

    // Pattern load; address 0 is written in the same cycle as start.
    for (int k = 0; k < 8192; k++) begin
      m1[k] = {32'(k), ~32'(k)};
      m2[k] = {32'(k + 32'h10000), 32'(k)};
    end
    load_dut(1);
    run_frame(1, -1, -1);
    frame_checks("pattern");
    for (int t = 0; t < 6; t++) begin
      for (int j = 0; j < 4; j++) begin
        e1r[j]  = 27'(tbl[t].c1 + j);
        e2i[j]  = 27'(tbl[t].c1 + j);
        e1c2[j] = (tbl[t].c2 < 0) ? 27'd0 : 27'(tbl[t].c2 + j);
        e2c2[j] = (tbl[t].c2 < 0) ? 27'd0 : 27'(tbl[t].c2 + j + 32'h10000);
      end
      cb = cap[tbl[t].beat];
      check({cb.x1c1r, cb.x2c1i, cb.x1c2r, cb.x2c2r, cb.i1, cb.i2} == {e1r, e2i, e1c2, e2c2, tbl[t].i1, tbl[t].i2},
            $sformatf("table_beat%0d", tbl[t].beat),
            $sformatf("%h", {cb.x1c1r, cb.x2c1i, cb.x1c2r, cb.x2c2r, cb.i1, cb.i2}),
            $sformatf("%h", {e1r, e2i, e1c2, e2c2, tbl[t].i1, tbl[t].i2}));
    end

    // Truncation of a field whose upper bits are discarded.
    m1[5] = 64'hFFFFFFFF_80000001;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 13'd5; wr_x1 = m1[5]; wr_x2 = m2[5];
    run_frame(0, -1, -1);
    frame_checks("trunc");
    check(cap[1].x1c1r[1] == 27'h7FFFFFF && cap[1].x1c1i[1] == 27'h0000001, "trunc_lane",
          $sformatf("r=%h i=%h", cap[1].x1c1r[1], cap[1].x1c1i[1]), "r=7ffffff i=0000001");

    // Write and start during RUN are ignored; the next replay must be unchanged.
    run_frame(0, 500, -1);
    frame_checks("busy_ignore");
    run_frame(0, -1, -1);
    frame_checks("replay");

    // Random contents.
    for (int k = 0; k < 8192; k++) begin
      m1[k] = {$urandom, $urandom};
      m2[k] = {$urandom, $urandom};
    end
    load_dut(0);
    run_frame(0, -1, -1);
    frame_checks("random");

    // Reset mid-frame, then a full replay of retained data.
    run_frame(0, -1, 300);
    run_frame(0, -1, -1);
    frame_checks("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
